uart_rx_sniffer: RTL and testbench

Synthesizable UART receiver that decodes the serial stream driven on the SoC `TXD` pin (8 data bits, no parity, 1 stop bit, LSB first) and presents received bytes through a small first-word-fall-through FIFO with a valid/ready interface. It sits at the far end of the SoC UART link: in the top-level testbench it attaches to `TXD` so console output is checked byte-by-byte. On the board it is the receive front-end for the expansion header.

---
 rtl/uart_rx_sniffer_if.sv | 9 +
 rtl/uart_rx_sniffer.sv | 133 +++++++++++++
 tb/tb_uart_rx_sniffer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_sniffer_if.sv
// Receive-side byte stream handshake: the producer drives data/valid, the consumer drives ready.
interface uart_rx_sniffer_if;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_ready;

   modport master (output rx_data, output rx_valid, input rx_ready);
   modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_sniffer.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority vote and a FWFT receive FIFO.
module uart_rx_sniffer #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                      clk50M,
   input  logic                      reset_n,
   input  logic                      rxd,
   uart_rx_sniffer_if.master         rx_if,
   output logic                      frame_err,
   output logic                      overrun,
   output logic                      busy
);
   localparam int DIV_RAW = (CLK_HZ + BAUD*8) / (BAUD*16);
   localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
   localparam int PW      = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int AW      = $clog2(FIFO_DEPTH);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   logic          s1_q, s1_d, rxs_q, rxs_d, rxs_prev_q, rxs_prev_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    phase_q, phase_d;
   logic [1:0]    hist_q, hist_d;
   logic [1:0]    state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    sh_q, sh_d;
   logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
   logic [7:0]    mem_q [FIFO_DEPTH];

   logic tick, eval, wrap, maj, push_req, fe, full, empty, pop, push_ok;

   assign tick = (presc_q == PW'(DIV-1));
   assign eval = tick && (phase_q == 4'd8);
   assign wrap = tick && (phase_q == 4'd15);
   // hist holds the samples taken on the ticks entering phases 7 and 8; rxs now is the phase-9 sample
   assign maj  = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs_q) | (hist_q[0] & rxs_q);

   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign empty = (wr_q == rd_q);
   assign pop   = !empty && rx_if.rx_ready;
   assign push_ok = push_req && (!full || pop);

   always_comb begin
      s1_d       = rxd;
      rxs_d      = s1_q;
      rxs_prev_d = rxs_q;
      presc_d    = tick ? '0 : presc_q + 1'b1;
      phase_d    = tick ? phase_q + 4'd1 : phase_q;
      hist_d     = tick ? {hist_q[0], rxs_q} : hist_q;
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      sh_d       = sh_q;
      push_req   = 1'b0;
      fe         = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rxs_q && rxs_prev_q) begin
               presc_d = '0;
               phase_d = 4'd0;
               state_d = START;
            end
         end
         START: begin
            if (eval && maj) begin
               state_d = IDLE;
            end else if (wrap) begin
               state_d   = DATA;
               bit_cnt_d = 3'd0;
            end
         end
         DATA: begin
            if (eval) sh_d = {maj, sh_q[7:1]};
            if (wrap) begin
               if (bit_cnt_q == 3'd7) state_d = STOP;
               else                   bit_cnt_d = bit_cnt_q + 3'd1;
            end
         end
         default: begin
            // leaving at mid-stop re-arms edge detection early enough for skewed back-to-back frames
            if (eval) begin
               push_req = maj;
               fe       = !maj;
               state_d  = IDLE;
            end
         end
      endcase
      wr_d = wr_q + (AW+1)'(push_ok);
      rd_d = rd_q + (AW+1)'(pop);
   end

   always_ff @(posedge clk50M or negedge reset_n) begin
      if (!reset_n) begin
         s1_q       <= 1'b1;
         rxs_q      <= 1'b1;
         rxs_prev_q <= 1'b1;
         presc_q    <= '0;
         phase_q    <= 4'd0;
         hist_q     <= 2'b11;
         state_q    <= IDLE;
         bit_cnt_q  <= 3'd0;
         sh_q       <= 8'h00;
         wr_q       <= '0;
         rd_q       <= '0;
      end else begin
         s1_q       <= s1_d;
         rxs_q      <= rxs_d;
         rxs_prev_q <= rxs_prev_d;
         presc_q    <= presc_d;
         phase_q    <= phase_d;
         hist_q     <= hist_d;
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         sh_q       <= sh_d;
         wr_q       <= wr_d;
         rd_q       <= rd_d;
      end
   end

   always_ff @(posedge clk50M) begin
      if (push_ok) mem_q[wr_q[AW-1:0]] <= sh_q;
   end

   assign rx_if.rx_valid = !empty;
   assign rx_if.rx_data  = empty ? 8'h00 : mem_q[rd_q[AW-1:0]];
   assign frame_err      = fe;
   assign overrun        = push_req && !push_ok;
   assign busy           = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rx_sniffer.sv
// Directed bench for uart_rx_sniffer at DIV=1 (16 clocks per bit).
module tb_uart_rx_sniffer;
   logic clk50M = 1'b0;
   logic reset_n, rxd;
   logic frame_err, overrun, busy;
   int   n_checks = 0;
   int   n_errors = 0;
   int   fe_cnt = 0, ov_cnt = 0, valid_cyc = 0;
   logic [7:0] got_q [$];

   uart_rx_sniffer_if rif ();

   uart_rx_sniffer #(.CLK_HZ(50_000_000), .BAUD(3_125_000), .FIFO_DEPTH(8)) dut (
      .clk50M(clk50M), .reset_n(reset_n), .rxd(rxd), .rx_if(rif.master),
      .frame_err(frame_err), .overrun(overrun), .busy(busy));

   always #5 clk50M = ~clk50M;

   always @(negedge clk50M) begin
      if (rif.rx_valid && rif.rx_ready) got_q.push_back(rif.rx_data);
      if (rif.rx_valid) valid_cyc++;
      if (frame_err) fe_cnt++;
      if (overrun) ov_cnt++;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk50M);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop, input int stop_len);
      rxd = 1'b0;
      wait_clks(16);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         wait_clks(16);
      end
      rxd = stop;
      wait_clks(16*stop_len);
      rxd = 1'b1;
   endtask

   task automatic test_reset;
      @(negedge clk50M);
      n_checks++; if (rif.rx_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", rif.rx_valid); end
      n_checks++; if (rif.rx_data !== 8'h00) begin n_errors++; $display("FAIL reset_data: got %h want 00", rif.rx_data); end
      n_checks++; if ({frame_err, overrun, busy} !== 3'b000) begin n_errors++; $display("FAIL reset_flags: got %b want 000", {frame_err, overrun, busy}); end
      wait_clks(1);
      reset_n = 1'b1;
      wait_clks(5);
   endtask

   task automatic test_single_byte;
      int g0 = got_q.size(), v0 = valid_cyc, f0 = fe_cnt, o0 = ov_cnt;
      rif.rx_ready = 1'b1;
      send_byte(8'hA5, 1'b1, 1);
      wait_clks(10);
      n_checks++; if (got_q.size() - g0 !== 1) begin n_errors++; $display("FAIL single_count: got %0d want 1", got_q.size() - g0); end
      else begin n_checks++; if (got_q[g0] !== 8'hA5) begin n_errors++; $display("FAIL single_data: got %h want a5", got_q[g0]); end end
      n_checks++; if (valid_cyc - v0 !== 1) begin n_errors++; $display("FAIL single_valid_len: got %0d want 1", valid_cyc - v0); end
      n_checks++; if (fe_cnt - f0 !== 0 || ov_cnt - o0 !== 0) begin n_errors++; $display("FAIL single_flags: fe %0d ov %0d want 0 0", fe_cnt - f0, ov_cnt - o0); end
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL single_busy: got %b want 0", busy); end
   endtask

   task automatic test_glitch;
      int g0 = got_q.size(), f0 = fe_cnt;
      rxd = 1'b0;
      wait_clks(3);
      @(negedge clk50M);
      n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL glitch_busy_rise: got %b want 1", busy); end
      @(posedge clk50M); #1;
      rxd = 1'b1;
      repeat (8) @(posedge clk50M);
      @(negedge clk50M);
      n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL glitch_busy_fall: got %b want 0", busy); end
      wait_clks(20);
      n_checks++; if (got_q.size() !== g0 || rif.rx_valid !== 1'b0 || fe_cnt !== f0) begin n_errors++; $display("FAIL glitch_no_push: pops %0d valid %b fe %0d want 0 0 0", got_q.size() - g0, rif.rx_valid, fe_cnt - f0); end
   endtask

   task automatic test_frame_err;
      int g0 = got_q.size(), f0 = fe_cnt, o0 = ov_cnt;
      rif.rx_ready = 1'b1;
      send_byte(8'h3C, 1'b0, 2);
      wait_clks(16);
      send_byte(8'h55, 1'b1, 1);
      wait_clks(10);
      n_checks++; if (fe_cnt - f0 !== 1) begin n_errors++; $display("FAIL ferr_pulses: got %0d want 1", fe_cnt - f0); end
      n_checks++; if (ov_cnt - o0 !== 0) begin n_errors++; $display("FAIL ferr_overrun: got %0d want 0", ov_cnt - o0); end
      n_checks++; if (got_q.size() - g0 !== 1) begin n_errors++; $display("FAIL ferr_count: got %0d want 1", got_q.size() - g0); end
      else begin n_checks++; if (got_q[g0] !== 8'h55) begin n_errors++; $display("FAIL ferr_next_byte: got %h want 55", got_q[g0]); end end
   endtask

   task automatic test_fill_overrun;
      int g0, v0, o0 = ov_cnt;
      rif.rx_ready = 1'b0;
      for (int b = 0; b < 9; b++) send_byte(8'(b), 1'b1, 1);
      wait_clks(10);
      n_checks++; if (ov_cnt - o0 !== 1) begin n_errors++; $display("FAIL fill_overrun: got %0d want 1", ov_cnt - o0); end
      n_checks++; if (rif.rx_valid !== 1'b1 || rif.rx_data !== 8'h00) begin n_errors++; $display("FAIL fill_head: valid %b data %h want 1 00", rif.rx_valid, rif.rx_data); end
      g0 = got_q.size(); v0 = valid_cyc;
      rif.rx_ready = 1'b1;
      wait_clks(10);
      n_checks++; if (valid_cyc - v0 !== 8 || got_q.size() - g0 !== 8) begin n_errors++; $display("FAIL drain_len: valid %0d pops %0d want 8 8", valid_cyc - v0, got_q.size() - g0); end
      else for (int i = 0; i < 8; i++) begin
         n_checks++; if (got_q[g0+i] !== 8'(i)) begin n_errors++; $display("FAIL drain_data[%0d]: got %h want %h", i, got_q[g0+i], 8'(i)); end
      end
      n_checks++; if (rif.rx_valid !== 1'b0) begin n_errors++; $display("FAIL drain_empty: got %b want 0", rif.rx_valid); end
   endtask

   task automatic test_full_pop;
      int g0, o0;
      logic [7:0] exp_b;
      rif.rx_ready = 1'b0;
      for (int b = 0; b < 8; b++) send_byte(8'h10 + 8'(b), 1'b1, 1);
      wait_clks(10);
      g0 = got_q.size(); o0 = ov_cnt;
      // STOP evaluation lands 156 edges after the start edge is driven
      fork
         send_byte(8'h99, 1'b1, 1);
         begin
            repeat (155) @(posedge clk50M);
            #1 rif.rx_ready = 1'b1;
            @(posedge clk50M);
            #1 rif.rx_ready = 1'b0;
         end
      join
      wait_clks(5);
      n_checks++; if (ov_cnt - o0 !== 0) begin n_errors++; $display("FAIL fullpop_overrun: got %0d want 0", ov_cnt - o0); end
      n_checks++; if (got_q.size() - g0 !== 1 || got_q[g0] !== 8'h10) begin n_errors++; $display("FAIL fullpop_pop: pops %0d want 1 of 10", got_q.size() - g0); end
      rif.rx_ready = 1'b1;
      wait_clks(12);
      n_checks++; if (got_q.size() - g0 !== 9) begin n_errors++; $display("FAIL fullpop_drain_len: got %0d want 9", got_q.size() - g0); end
      else for (int i = 1; i < 9; i++) begin
         exp_b = (i == 8) ? 8'h99 : 8'h10 + 8'(i);
         n_checks++; if (got_q[g0+i] !== exp_b) begin n_errors++; $display("FAIL fullpop_data[%0d]: got %h want %h", i, got_q[g0+i], exp_b); end
      end
   endtask

   task automatic test_reset_mid;
      int g0;
      rif.rx_ready = 1'b0;
      send_byte(8'h42, 1'b1, 1);
      wait_clks(4);
      n_checks++; if (rif.rx_valid !== 1'b1 || rif.rx_data !== 8'h42) begin n_errors++; $display("FAIL rstmid_prefill: valid %b data %h want 1 42", rif.rx_valid, rif.rx_data); end
      rxd = 1'b0;
      wait_clks(16);
      for (int i = 0; i < 4; i++) wait_clks(16);
      rxd = 1'b1;
      wait_clks(8);
      reset_n = 1'b0;
      #1;
      n_checks++; if ({rif.rx_valid, rif.rx_data, frame_err, overrun, busy} !== 12'h000) begin n_errors++; $display("FAIL rstmid_outputs: valid %b data %h fe %b ov %b busy %b want all 0", rif.rx_valid, rif.rx_data, frame_err, overrun, busy); end
      wait_clks(4);
      reset_n = 1'b1;
      wait_clks(20);
      send_byte(8'h81, 1'b1, 1);
      wait_clks(4);
      n_checks++; if (rif.rx_valid !== 1'b1 || rif.rx_data !== 8'h81) begin n_errors++; $display("FAIL rstmid_head: valid %b data %h want 1 81", rif.rx_valid, rif.rx_data); end
      g0 = got_q.size();
      rif.rx_ready = 1'b1;
      wait_clks(4);
      n_checks++; if (got_q.size() - g0 !== 1 || rif.rx_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_only_one: pops %0d valid %b want 1 0", got_q.size() - g0, rif.rx_valid); end
   endtask

   initial begin
      reset_n = 1'b0;
      rxd = 1'b1;
      rif.rx_ready = 1'b0;
      wait_clks(3);
      test_reset;
      test_single_byte;
      test_glitch;
      test_frame_err;
      test_fill_overrun;
      test_full_pop;
      test_reset_mid;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
